// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// The pipe_ld bit indices name the pipeline register each load enable drives.
package pipe_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ERROR = 2'd2
    } state_e;

    localparam int unsigned PC     = 0;
    localparam int unsigned IF_ID  = 1;
    localparam int unsigned ID_EX  = 2;
    localparam int unsigned EX_MEM = 3;
    localparam int unsigned MEM_WB = 4;

    localparam logic [4:0] LD_NONE = 5'b00000;
    localparam logic [4:0] LD_ALL  = 5'b11111;
    // A hazard freezes the front end (PC, IF/ID) while the back end drains.
    localparam logic [4:0] LD_HOLD_FRONT = LD_ALL & ~((5'b1 << PC) | (5'b1 << IF_ID));

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter: advances on inc_i and sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: memory stall > branch squash > data hazard,
// with a bounded memory wait that falls into a sticky ERROR state on timeout.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             s_req,
    output logic [4:0]       pipe_ld,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             status_ld,
    output logic             mem_busy,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Outputs are purely combinational so the pipeline reacts in the same cycle.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        pipe_ld     = LD_NONE;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    state_d = ST_WAIT;
                    wait_d  = '0;
                end else if (branch_taken) begin
                    pipe_ld     = LD_ALL;
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end else if (hazard) begin
                    pipe_ld     = LD_HOLD_FRONT;
                    flush_id_ex = 1'b1;
                end else begin
                    pipe_ld = LD_ALL;
                end
            end
            ST_WAIT: begin
                // A completing access on the last allowed cycle still beats the timeout.
                if (mem_ready) begin
                    pipe_ld = LD_ALL;
                    state_d = ST_RUN;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ST_ERROR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign status_ld   = s_req & pipe_ld[EX_MEM];
    assign mem_busy    = (state_q == ST_WAIT);
    assign mem_timeout = (state_q == ST_ERROR);

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_stall_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (~pipe_ld[PC]),
        .count_o(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed vectors queue their expected
// outputs, and a monitor compares them against the DUT every falling edge.
module tb_pipe_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hazard = 1'b0;
    logic       branch_taken = 1'b0;
    logic       mem_req = 1'b0;
    logic       mem_ready = 1'b0;
    logic       s_req = 1'b0;
    logic [4:0] pipe_ld;
    logic       flush_if_id;
    logic       flush_id_ex;
    logic       status_ld;
    logic       mem_busy;
    logic       mem_timeout;
    logic [3:0] stall_cnt;

    typedef struct {
        string       name;
        logic [13:0] vec;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;

    pipe_stall_ctrl #(
        .WAIT_MAX(15),
        .CNT_W   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hazard      (hazard),
        .branch_taken(branch_taken),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .s_req       (s_req),
        .pipe_ld     (pipe_ld),
        .flush_if_id (flush_if_id),
        .flush_id_ex (flush_id_ex),
        .status_ld   (status_ld),
        .mem_busy    (mem_busy),
        .mem_timeout (mem_timeout),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] ev(input logic [4:0] p, input logic fif, input logic fie,
                                       input logic sld, input logic busy, input logic tmo,
                                       input logic [3:0] cnt);
        return {p, fif, fie, sld, busy, tmo, cnt};
    endfunction

    // Drive one cycle of inputs just after the rising edge and queue the expectation.
    task automatic applyStimulus(input string name, input logic rstV, input logic [4:0] inVec,
                                 input logic [13:0] expVec);
        exp_t e;
        @(posedge clk);
        #1;
        rst = rstV;
        {hazard, branch_taken, mem_req, mem_ready, s_req} = inVec;
        e.name = name;
        e.vec  = expVec;
        q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [13:0] act;
        act = {pipe_ld, flush_if_id, flush_id_ex, status_ld, mem_busy, mem_timeout, stall_cnt};
        checks++;
        if (act !== e.vec) begin
            fails++;
            $display("[TB] FAIL %s: got pipe_ld=%b fif=%b fie=%b sld=%b busy=%b tmo=%b cnt=%0d, want pipe_ld=%b fif=%b fie=%b sld=%b busy=%b tmo=%b cnt=%0d",
                     e.name, act[13:9], act[8], act[7], act[6], act[5], act[4], act[3:0],
                     e.vec[13:9], e.vec[8], e.vec[7], e.vec[6], e.vec[5], e.vec[4], e.vec[3:0]);
        end
    endtask

    // Monitor: outputs are sampled mid-cycle, away from the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) checkOutput(q.pop_front());
        end
    end

    initial begin
        // Basic RUN behaviour
        applyStimulus("reset",        1'b1, 5'b00000, ev(5'b11111, 0, 0, 0, 0, 0, 4'd0));
        applyStimulus("idle",         1'b0, 5'b00000, ev(5'b11111, 0, 0, 0, 0, 0, 4'd0));
        applyStimulus("hazard",       1'b0, 5'b10000, ev(5'b11100, 0, 1, 0, 0, 0, 4'd0));
        applyStimulus("after_haz",    1'b0, 5'b00000, ev(5'b11111, 0, 0, 0, 0, 0, 4'd1));
        applyStimulus("br_and_haz",   1'b0, 5'b11000, ev(5'b11111, 1, 1, 0, 0, 0, 4'd1));
        applyStimulus("after_br",     1'b0, 5'b00000, ev(5'b11111, 0, 0, 0, 0, 0, 4'd1));
        applyStimulus("haz_sreq",     1'b0, 5'b10001, ev(5'b11100, 0, 1, 1, 0, 0, 4'd1));
        // Short memory wait: three frozen cycles then release
        applyStimulus("mem_stall_s",  1'b0, 5'b00101, ev(5'b00000, 0, 0, 0, 0, 0, 4'd2));
        applyStimulus("wait1",        1'b0, 5'b10101, ev(5'b00000, 0, 0, 0, 1, 0, 4'd3));
        applyStimulus("wait2",        1'b0, 5'b00100, ev(5'b00000, 0, 0, 0, 1, 0, 4'd4));
        applyStimulus("wait_done",    1'b0, 5'b11111, ev(5'b11111, 0, 0, 1, 1, 0, 4'd5));
        applyStimulus("run_back",     1'b0, 5'b00000, ev(5'b11111, 0, 0, 0, 0, 0, 4'd5));
        applyStimulus("rdy_branch",   1'b0, 5'b01110, ev(5'b11111, 1, 1, 0, 0, 0, 4'd5));
        applyStimulus("rdy_hazard",   1'b0, 5'b10110, ev(5'b11100, 0, 1, 0, 0, 0, 4'd5));
        applyStimulus("idle3",        1'b0, 5'b00000, ev(5'b11111, 0, 0, 0, 0, 0, 4'd6));
        applyStimulus("idle_sreq",    1'b0, 5'b00001, ev(5'b11111, 0, 0, 1, 0, 0, 4'd6));
        // Timeout into ERROR; the stall counter saturates along the way
        applyStimulus("rst1",         1'b1, 5'b00000, ev(5'b11111, 0, 0, 0, 0, 0, 4'd0));
        applyStimulus("to_enter",     1'b0, 5'b00100, ev(5'b00000, 0, 0, 0, 0, 0, 4'd0));
        for (int k = 0; k < 15; k++)
            applyStimulus("to_wait",  1'b0, 5'b00100, ev(5'b00000, 0, 0, 0, 1, 0, 4'(k + 1)));
        applyStimulus("error",        1'b0, 5'b00100, ev(5'b00000, 0, 0, 0, 0, 1, 4'd15));
        applyStimulus("error_rdy",    1'b0, 5'b11111, ev(5'b00000, 0, 0, 0, 0, 1, 4'd15));
        applyStimulus("error_hold",   1'b0, 5'b00000, ev(5'b00000, 0, 0, 0, 0, 1, 4'd15));
        applyStimulus("rst_err",      1'b1, 5'b00000, ev(5'b11111, 0, 0, 0, 0, 0, 4'd0));
        applyStimulus("post_rst",     1'b0, 5'b00000, ev(5'b11111, 0, 0, 0, 0, 0, 4'd0));
        // mem_ready on the final allowed wait cycle beats the timeout
        applyStimulus("bd_enter",     1'b0, 5'b00100, ev(5'b00000, 0, 0, 0, 0, 0, 4'd0));
        for (int k = 0; k < 14; k++)
            applyStimulus("bd_wait",  1'b0, 5'b00100, ev(5'b00000, 0, 0, 0, 1, 0, 4'(k + 1)));
        applyStimulus("bd_last_rdy",  1'b0, 5'b00110, ev(5'b11111, 0, 0, 0, 1, 0, 4'd15));
        applyStimulus("bd_run",       1'b0, 5'b00000, ev(5'b11111, 0, 0, 0, 0, 0, 4'd15));
        // Reset in the middle of a wait returns straight to RUN
        applyStimulus("mw_enter",     1'b0, 5'b00100, ev(5'b00000, 0, 0, 0, 0, 0, 4'd15));
        applyStimulus("mw_wait",      1'b0, 5'b00100, ev(5'b00000, 0, 0, 0, 1, 0, 4'd15));
        applyStimulus("mw_rst",       1'b1, 5'b00100, ev(5'b00000, 0, 0, 0, 0, 0, 4'd0));
        applyStimulus("mw_rst_idle",  1'b1, 5'b00000, ev(5'b11111, 0, 0, 0, 0, 0, 4'd0));
        applyStimulus("mw_after",     1'b0, 5'b00000, ev(5'b11111, 0, 0, 0, 0, 0, 4'd0));
        applyStimulus("mw_hazard",    1'b0, 5'b10000, ev(5'b11100, 0, 1, 0, 0, 0, 4'd0));
        applyStimulus("mw_cnt",       1'b0, 5'b00000, ev(5'b11111, 0, 0, 0, 0, 0, 4'd1));

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            fails++;
            $display("[TB] FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 The block SHALL have parameter WAIT_MAX, default 15, the memory-wait cycle limit before timeout (legal 2..255).
REQ-002 The block SHALL have parameter CNT_W, default 16, the stall-counter width.
REQ-003 The block SHALL have clk, input, 1, clock; all state updates on posedge clk.
REQ-004 The block SHALL have rst, input, 1, reset: asynchronous, active-high.
REQ-005 The block SHALL have hazard, input, 1, ID-stage data hazard against EX/MEM destination.
REQ-006 The block SHALL have branch_taken, input, 1, branch resolved taken in EX.
REQ-007 The block SHALL have mem_req, input, 1, MEM stage holds a load/store.
REQ-008 The block SHALL have mem_ready, input, 1, memory completes the access this cycle.
REQ-009 The block SHALL have s_req, input, 1, EX instruction requests a flag update (S bit).
REQ-010 The block SHALL have pipe_ld, output, 5, load enables [0]=PC, [1]=IF/ID, [2]=ID/EX, [3]=EX/MEM, [4]=MEM/WB.
REQ-011 The block SHALL have flush_if_id and flush_id_ex, outputs, 1 each, synchronous-clear requests to those pipeline registers.
REQ-012 The block SHALL have status_ld, output, 1, load enable for the flag register.
REQ-013 The block SHALL have mem_busy, output, 1, high while in WAIT.
REQ-014 The block SHALL have mem_timeout, output, 1, sticky high in ERROR.
REQ-015 The block SHALL have stall_cnt, output, CNT_W, count of cycles with pipe_ld[0]=0.

Function
REQ-016 The FSM SHALL have states RUN, WAIT, ERROR; pipe_ld, flush_*, status_ld SHALL be combinational from state and inputs (zero latency).
REQ-017 In RUN with mem_req=1 and mem_ready=0, pipe_ld SHALL be 5'b00000, flushes 0, and next state WAIT.
REQ-018 In RUN with mem_req=0 or mem_ready=1, and branch_taken=1, pipe_ld SHALL be 5'b11111 and flush_if_id=flush_id_ex=1.
REQ-019 In RUN, no memory stall, branch_taken=0, hazard=1: pipe_ld SHALL be 5'b11100, flush_id_ex=1, flush_if_id=0.
REQ-020 In RUN with no condition active, pipe_ld SHALL be 5'b11111 with both flushes 0.
REQ-021 Priority SHALL be memory stall > branch > hazard; branch overrides hazard because the hazarding instruction is squashed.
REQ-022 In WAIT with mem_ready=0, pipe_ld SHALL be 0 and the wait counter SHALL increment; with mem_ready=1, pipe_ld SHALL be 5'b11111, branch/hazard ignored that cycle, next state RUN.
REQ-023 When the wait counter reaches WAIT_MAX-1 with mem_ready=0, next state SHALL be ERROR; mem_ready=1 on that same cycle SHALL win (go RUN).
REQ-024 The wait counter SHALL clear on every entry to WAIT.
REQ-025 ERROR SHALL drive pipe_ld=0, flushes 0, mem_timeout=1 and SHALL exit only on rst.
REQ-026 status_ld SHALL equal s_req AND pipe_ld[3]; never set in WAIT (unless mem_ready) or ERROR.
REQ-027 stall_cnt SHALL increment each cycle pipe_ld[0]=0 and saturate at all-ones.
REQ-028 mem_busy SHALL be 1 exactly when state is WAIT.

Reset
REQ-029 rst SHALL force state RUN, wait counter 0, stall_cnt 0, mem_timeout 0 immediately, independent of clk.
REQ-030 During rst, outputs SHALL reflect RUN with current inputs; rst asserted mid-WAIT or in ERROR SHALL return to RUN with no residual stall.

Structure
REQ-031 A shared package SHALL hold the state enum and the pipe_ld bit-index constants (PC, IF_ID, ID_EX, EX_MEM, MEM_WB).
REQ-032 One sub-module, sat_counter (parameter width, inc, async rst), SHALL implement stall_cnt.

Verification
REQ-033 hazard=1 for one cycle in RUN -> pipe_ld=5'b11100, flush_id_ex=1, stall_cnt 0->1.
REQ-034 branch_taken=1 and hazard=1 together -> pipe_ld=5'b11111, both flushes 1, stall_cnt unchanged.
REQ-035 mem_req=1, mem_ready=0 for 3 cycles then 1 -> 3 cycles pipe_ld=0, mem_busy=1 for cycles 2-4, 4th cycle pipe_ld=5'b11111, stall_cnt=3.
REQ-036 mem_req=1, mem_ready never asserted, WAIT_MAX=15 -> ERROR entered, mem_timeout=1 held; rst -> RUN, mem_timeout=0, stall_cnt=0.
REQ-037 s_req=1 during a memory stall -> status_ld=0; s_req=1 with hazard only -> status_ld=1.
REQ-038 CNT_W=4, 20 consecutive stall cycles -> stall_cnt holds 4'hF.
